// File: rtl/mux4_rr_scheduler_pkg.sv
// Shared types and constants for the 4-requester round-robin mux scheduler.
// Provides state encodings, requester count, select width and the rotate-priority pick.
package mux4_rr_scheduler_pkg;

    localparam int NREQ = 4;
    localparam int SELW = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // First requester at or after ptr, wrapping modulo 4.
    // Walking the offsets downwards lets the smallest offset win.
    function automatic logic [SELW-1:0] rr_pick(
        input logic [NREQ-1:0] req,
        input logic [SELW-1:0] ptr
    );
        logic [SELW-1:0] pick;
        logic [SELW-1:0] idx;
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr + SELW'(i);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux4_rr_scheduler_if.sv
// Requester/consumer bundle of the round-robin mux scheduler.
// master: drives req and i0..i3; slave: drives gnt, sel, y_data, y_valid, busy.
interface mux4_rr_scheduler_if #(
    parameter int W = 1
) ();

    logic [3:0]   req;
    logic [W-1:0] i0;
    logic [W-1:0] i1;
    logic [W-1:0] i2;
    logic [W-1:0] i3;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [W-1:0] y_data;
    logic         y_valid;
    logic         busy;

    modport master (
        output req, i0, i1, i2, i3,
        input  gnt, sel, y_data, y_valid, busy
    );

    modport slave (
        input  req, i0, i1, i2, i3,
        output gnt, sel, y_data, y_valid, busy
    );

endinterface

// File: rtl/mux4_rr_scheduler_dp.sv
// W-bit 4:1 dataflow multiplexer shared by the scheduler's requesters.
// Ports: i0..i3 data inputs, sel {s1,s0}, y selected output.
module mux4_dp #(
    parameter int W = 1
) (
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] i2,
    input  logic [W-1:0] i3,
    input  logic [1:0]   sel,
    output logic [W-1:0] y
);

    assign y = sel[1] ? (sel[0] ? i3 : i2)
                      : (sel[0] ? i1 : i0);

endmodule

// File: rtl/mux4_rr_scheduler.sv
// Round-robin owner of a shared 4:1 mux with bounded tenure and a turnaround gap.
// Ports: clk, rst (sync, active high), bus (slave side: req/i0..i3 in; gnt/sel/y_data/y_valid/busy out).
module mux4_rr_scheduler
    import mux4_rr_scheduler_pkg::*;
#(
    parameter int W        = 1,
    parameter int MAX_HOLD = 4
) (
    input logic               clk,
    input logic               rst,
    mux4_rr_scheduler_if.slave bus
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [7:0]        hold_q, hold_d;
    logic              busy_q;
    logic [SELW-1:0]   win;
    logic [W-1:0]      mux_y;
    logic              y_valid;

    assign win = rr_pick(bus.req, ptr_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            ST_GRANT: begin
                // sel is left alone on release so the mux stays put through GAP.
                if (!bus.req[sel_q] || hold_q == HOLD_LAST) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ST_IDLE, ST_GAP: begin
                if (|bus.req) begin
                    state_d = ST_GRANT;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
                    sel_d   = win;
                    ptr_d   = win + 2'd1;
                    hold_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    mux4_dp #(.W(W)) u_dp (
        .i0  (bus.i0),
        .i1  (bus.i1),
        .i2  (bus.i2),
        .i3  (bus.i3),
        .sel (sel_q),
        .y   (mux_y)
    );

    // The owner's live req gates validity, so a drop shows up before gnt falls.
    assign y_valid     = (state_q == ST_GRANT) & bus.req[sel_q];
    assign bus.y_valid = y_valid;
    assign bus.y_data  = y_valid ? mux_y : '0;
    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Self-checking bench: two schedulers (MAX_HOLD 4 and 1) share stimulus,
// compared every cycle against a tenure-level reference model.
module tb_mux4_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_v;
    logic [3:0] dat_v;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the channel, how many cycles they have used,
    // whether a turnaround cycle is in progress, and where the search starts.
    int m_owner [2];
    int m_used  [2];
    int m_ptr   [2];
    int m_sel   [2];
    bit m_gap   [2];
    int maxh    [2] = '{4, 1};

    always #5 clk = ~clk;

    mux4_rr_scheduler_if #(.W(1)) ifa ();
    mux4_rr_scheduler_if #(.W(1)) ifb ();

    mux4_rr_scheduler #(.W(1), .MAX_HOLD(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    mux4_rr_scheduler #(.W(1), .MAX_HOLD(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int n);
        if (rst) begin
            m_owner[n] = -1;
            m_used[n]  = 0;
            m_ptr[n]   = 0;
            m_sel[n]   = 0;
            m_gap[n]   = 1'b0;
        end else if (m_owner[n] >= 0) begin
            if (!req_v[m_owner[n]] || m_used[n] == maxh[n]) begin
                m_owner[n] = -1;
                m_gap[n]   = 1'b1;
            end else begin
                m_used[n]++;
            end
        end else begin
            m_gap[n] = 1'b0;
            for (int d = 0; d < 4; d++) begin
                if (m_owner[n] < 0 && req_v[(m_ptr[n] + d) % 4]) begin
                    m_owner[n] = (m_ptr[n] + d) % 4;
                end
            end
            if (m_owner[n] >= 0) begin
                m_sel[n]  = m_owner[n];
                m_ptr[n]  = (m_owner[n] + 1) % 4;
                m_used[n] = 1;
            end
        end
    endtask

    task automatic cmp(input int n, input string ph, input logic [3:0] g,
                       input logic [1:0] s, input logic yd, input logic yv,
                       input logic b);
        logic [3:0] eg;
        logic       ev;
        logic       ed;
        eg = (m_owner[n] >= 0) ? 4'(1 << m_owner[n]) : 4'd0;
        ev = (m_owner[n] >= 0) && req_v[m_owner[n]];
        ed = ev ? dat_v[m_sel[n]] : 1'b0;
        check($sformatf("%s%0d_gnt", ph, n), 32'(g), 32'(eg));
        check($sformatf("%s%0d_sel", ph, n), 32'(s), 32'(m_sel[n]));
        check($sformatf("%s%0d_yv", ph, n), 32'(yv), 32'(ev));
        check($sformatf("%s%0d_yd", ph, n), 32'(yd), 32'(ed));
        check($sformatf("%s%0d_busy", ph, n), 32'(b),
              32'((m_owner[n] >= 0) || m_gap[n]));
    endtask

    task automatic check_all(input string ph);
        cmp(0, ph, ifa.gnt, ifa.sel, ifa.y_data, ifa.y_valid, ifa.busy);
        cmp(1, ph, ifb.gnt, ifb.sel, ifb.y_data, ifb.y_valid, ifb.busy);
    endtask

    task automatic apply(input logic [3:0] r, input logic [3:0] d, input logic rs);
        req_v   = r;
        dat_v   = d;
        rst     = rs;
        ifa.req = r;
        ifb.req = r;
        ifa.i0  = d[0];
        ifa.i1  = d[1];
        ifa.i2  = d[2];
        ifa.i3  = d[3];
        ifb.i0  = d[0];
        ifb.i1  = d[1];
        ifb.i2  = d[2];
        ifb.i3  = d[3];
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] d, input logic rs);
        apply(r, d, rs);
        #1;
        check_all("drv");
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_all("tick");
    endtask

    initial begin
        apply(4'b1111, 4'b0000, 1'b1);
        m_owner = '{-1, -1};

        // Reset with every request high, then release.
        tick();
        tick();
        check("t1_rst_gnt", 32'(ifa.gnt), 32'd0);
        check("t1_rst_yd", 32'(ifa.y_data), 32'd0);
        drive(4'b1111, 4'b0000, 1'b0);
        tick();
        check("t1_first_gnt", 32'(ifa.gnt), 32'h1);

        // Single requester: 4-cycle tenures separated by one gap.
        drive(4'b0100, 4'b0100, 1'b1);
        tick();
        drive(4'b0100, 4'b0100, 1'b0);
        for (int c = 0; c < 12; c++) tick();

        // All requesters: rotation 0,1,2,3,0.
        drive(4'b1111, 4'b1010, 1'b1);
        tick();
        drive(4'b1111, 4'b1010, 1'b0);
        for (int c = 0; c < 25; c++) tick();

        // Early drop of owner 1 while requester 3 waits.
        drive(4'b1010, 4'b0010, 1'b1);
        tick();
        drive(4'b1010, 4'b0010, 1'b0);
        tick();
        check("t4_own1", 32'(ifa.gnt), 32'h2);
        tick();
        drive(4'b1000, 4'b0010, 1'b0);
        check("t4_drop_gnt", 32'(ifa.gnt), 32'h2);
        check("t4_drop_yv", 32'(ifa.y_valid), 32'd0);
        tick();
        check("t4_gap", 32'(ifa.gnt), 32'd0);
        tick();
        check("t4_own3", 32'(ifa.gnt), 32'h8);

        // Reset during owner 2's second cycle must also clear ptr.
        drive(4'b0100, 4'b0100, 1'b1);
        tick();
        drive(4'b0100, 4'b0100, 1'b0);
        tick();
        tick();
        drive(4'b0101, 4'b0101, 1'b1);
        tick();
        check("t5_idle", 32'(ifa.busy), 32'd0);
        drive(4'b0101, 4'b0101, 1'b0);
        tick();
        check("t5_ptr0", 32'(ifa.gnt), 32'h1);

        // Datapath sweep for each owner across all 16 input patterns.
        for (int k = 0; k < 4; k++) begin
            drive(4'(1 << k), 4'b0000, 1'b1);
            tick();
            drive(4'(1 << k), 4'b0000, 1'b0);
            tick();
            for (int v = 0; v < 16; v++) begin
                drive(4'(1 << k), 4'(v), 1'b0);
                tick();
            end
        end

        // Random traffic with sticky requests and rare resets.
        drive(4'b0000, 4'b0000, 1'b1);
        tick();
        for (int c = 0; c < 400; c++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : req_v;
            drive(r, 4'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
